// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// Stream: a byte moves on any rising clk edge where in_valid && in_ready; the source holds in_byte stable while in_valid waits for in_ready.
interface prog_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_byte;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;

   // master: byte source / memory side; slave: the loader
   modport master (
      output in_valid, in_byte,
      input  in_ready, mem_write, mem_address, mem_write_data
   );
   modport slave (
      input  in_valid, in_byte,
      output in_ready, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program memory loader: framed big-endian word stream with length
// header and additive checksum; releases the processor only on a verified frame.
module prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   prog_loader_if.slave bus,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] word_count,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_LEN_HI = 3'd0,
      S_LEN_LO = 3'd1,
      S_DATA   = 3'd2,
      S_WR     = 3'd3,
      S_CSUM   = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state;
   logic [15:0] len;
   logic [23:0] word_acc;
   logic [7:0]  csum;
   logic [1:0]  byte_idx;
   logic        xfer;
   logic [15:0] len_new;

   assign bus.in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_DATA)   || (state == S_CSUM);
   assign busy         = (state == S_LEN_LO) || (state == S_DATA) ||
                         (state == S_WR)     || (state == S_CSUM);
   assign cpu_reset    = (state != S_DONE);
   assign state_dbg    = state;
   assign xfer         = bus.in_valid && bus.in_ready;
   assign len_new      = {len[15:8], bus.in_byte};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state              <= S_LEN_HI;
         bus.mem_write      <= 1'b0;
         bus.mem_address    <= BASE_ADDR;
         bus.mem_write_data <= 32'h0;
         done               <= 1'b0;
         error              <= 1'b0;
         word_count         <= 16'h0;
         len                <= 16'h0;
         word_acc           <= 24'h0;
         csum               <= 8'h0;
         byte_idx           <= 2'd0;
      end else begin
         case (state)
            S_LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= bus.in_byte;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  len[7:0] <= bus.in_byte;
                  if ({1'b0, len_new} > MAX_LEN) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else if (len_new == 16'h0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  word_acc <= {word_acc[15:0], bus.in_byte};
                  csum     <= csum + bus.in_byte;
                  byte_idx <= byte_idx + 2'd1;
                  // Fourth byte completes the word: present it to memory next cycle.
                  if (byte_idx == 2'd3) begin
                     state              <= S_WR;
                     bus.mem_write      <= 1'b1;
                     bus.mem_write_data <= {word_acc, bus.in_byte};
                     bus.mem_address    <= BASE_ADDR + {14'h0, word_count, 2'b00};
                  end
               end
            end
            S_WR: begin
               bus.mem_write <= 1'b0;
               word_count    <= word_count + 16'd1;
               if (({1'b0, word_count} + 17'd1) < {1'b0, len}) begin
                  state <= S_DATA;
               end else begin
                  state <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  if (bus.in_byte == csum) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
            S_DONE: state <= S_DONE;
            S_ERR:  state <= S_ERR;
            default: begin
               state <= S_ERR;
               error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame vector table plus hand-written
// sequences for mid-frame reset and a non-zero base address.
module tb_prog_loader;

   typedef struct {
      logic [15:0] len;
      logic [63:0] words;
      logic [7:0]  csum;
      int          n_send;
      bit          send_csum;
      bit          gaps;
      bit          exp_done;
      bit          exp_err;
      logic [15:0] exp_wc;
      int          exp_writes;
   } vec_t;

   localparam int NV = 8;

   logic clk;
   logic reset;
   logic cpu_reset0, busy0, done0, error0;
   logic cpu_reset1, busy1, done1, error1;
   logic [15:0] word_count0, word_count1;
   logic [2:0]  state_dbg0, state_dbg1;

   int pass_cnt = 0;
   int total_cnt = 0;
   int proto_err = 0;
   logic prev_mw0 = 1'b0;
   logic [64:0] exp_q[$];
   logic [64:0] got_q[$];
   vec_t vecs[NV];

   prog_loader_if bus0 ();
   prog_loader_if bus1 ();

   prog_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0.slave),
      .cpu_reset(cpu_reset0), .busy(busy0), .done(done0), .error(error0),
      .word_count(word_count0), .state_dbg(state_dbg0)
   );

   prog_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(1024)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave),
      .cpu_reset(cpu_reset1), .busy(busy1), .done(done1), .error(error1),
      .word_count(word_count1), .state_dbg(state_dbg1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // write capture and handshake invariants, sampled mid-cycle
   always @(negedge clk) begin
      if (bus0.mem_write) got_q.push_back({1'b0, bus0.mem_address, bus0.mem_write_data});
      if (bus1.mem_write) got_q.push_back({1'b1, bus1.mem_address, bus1.mem_write_data});
      if (busy0 && (bus0.in_ready == bus0.mem_write)) proto_err++;
      if (!busy0 && bus0.mem_write) proto_err++;
      if (bus0.mem_write && prev_mw0) proto_err++;
      prev_mw0 <= bus0.mem_write;
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   // driver tasks; all start and end 1 time unit after a rising edge
   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [7:0] b);
      if (sel) begin
         bus1.in_valid = v;
         bus1.in_byte  = b;
      end else begin
         bus0.in_valid = v;
         bus0.in_byte  = b;
      end
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input bit gaps);
      bit ok;
      int k;
      if (gaps) begin
         k = $urandom_range(0, 1);
         set_in(sel, 1'b0, 8'($urandom_range(0, 255)));
         repeat (k) @(posedge clk);
         #1;
      end
      set_in(sel, 1'b1, b);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if ((sel ? bus1.in_ready : bus0.in_ready) === 1'b1) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      set_in(sel, 1'b0, 8'h00);
      if (!ok) chk("send_timeout", 65'(ok), 65'd1);
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w, input bit gaps);
      for (int i = 3; i >= 0; i--) send_byte(sel, w[8*i +: 8], gaps);
   endtask

   // scoreboard compare of captured writes against expected queue
   task automatic check_writes(input string name);
      chk({name, "_nwrites"}, 65'(got_q.size()), 65'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({name, "_write"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_vals0(input string name);
      chk({name, "_in_ready"},  65'(bus0.in_ready), 65'd1);
      chk({name, "_mem_write"}, 65'(bus0.mem_write), 65'd0);
      chk({name, "_mem_addr"},  65'(bus0.mem_address), 65'h0);
      chk({name, "_mem_data"},  65'(bus0.mem_write_data), 65'h0);
      chk({name, "_cpu_reset"}, 65'(cpu_reset0), 65'd1);
      chk({name, "_busy"},      65'(busy0), 65'd0);
      chk({name, "_done"},      65'(done0), 65'd0);
      chk({name, "_error"},     65'(error0), 65'd0);
      chk({name, "_wc"},        65'(word_count0), 65'd0);
   endtask

   initial begin
      vec_t v;
      logic [63:0] wd;
      reset = 1'b0;
      set_in(1'b0, 1'b0, 8'h00);
      set_in(1'b1, 1'b0, 8'h00);

      vecs[0] = '{16'h0002, 64'h12345678_9ABCDEF0, 8'h38, 2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 2};
      vecs[1] = '{16'h0002, 64'h12345678_9ABCDEF0, 8'h39, 2, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 2};
      vecs[2] = '{16'h0401, 64'h0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 0};
      vecs[3] = '{16'h0000, 64'h0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 0};
      vecs[4] = '{16'h0002, 64'h12345678_9ABCDEF0, 8'h38, 2, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 2};
      vecs[5] = '{16'h0001, 64'hAABBCCDD_00000000, 8'h0E, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 1};
      vecs[6] = '{16'h0000, 64'h0, 8'h05, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 0};
      vecs[7] = '{16'hFFFF, 64'h0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 0};

      idle(2);
      reset = 1'b1;
      #1;
      check_reset_vals0("reset");

      for (int n = 0; n < NV; n++) begin
         v = vecs[n];
         wd = v.words;
         do_reset();
         got_q.delete();
         for (int i = 0; i < v.exp_writes; i++)
            exp_q.push_back({1'b0, 32'(4 * i), wd[63 - 32*i -: 32]});
         send_byte(1'b0, v.len[15:8], v.gaps);
         send_byte(1'b0, v.len[7:0], v.gaps);
         for (int i = 0; i < v.n_send; i++) send_word(1'b0, wd[63 - 32*i -: 32], v.gaps);
         if (v.send_csum) send_byte(1'b0, v.csum, v.gaps);
         idle(4);
         chk($sformatf("v%0d_done", n),      65'(done0), 65'(v.exp_done));
         chk($sformatf("v%0d_error", n),     65'(error0), 65'(v.exp_err));
         chk($sformatf("v%0d_cpu_reset", n), 65'(cpu_reset0), 65'(!v.exp_done));
         chk($sformatf("v%0d_busy", n),      65'(busy0), 65'd0);
         chk($sformatf("v%0d_in_ready", n),  65'(bus0.in_ready), 65'd0);
         chk($sformatf("v%0d_wc", n),        65'(word_count0), 65'(v.exp_wc));
         check_writes($sformatf("v%0d", n));
      end

      // reset after six data bytes of a two-word frame
      do_reset();
      send_byte(1'b0, 8'h00, 1'b0);
      send_byte(1'b0, 8'h02, 1'b0);
      send_word(1'b0, 32'h12345678, 1'b0);
      send_byte(1'b0, 8'h9A, 1'b0);
      send_byte(1'b0, 8'hBC, 1'b0);
      exp_q.push_back({1'b0, 32'h0, 32'h12345678});
      do_reset();
      check_reset_vals0("midrst");
      idle(3);
      check_writes("midrst");
      exp_q.push_back({1'b0, 32'h0, 32'hAABBCCDD});
      send_byte(1'b0, 8'h00, 1'b0);
      send_byte(1'b0, 8'h01, 1'b0);
      send_word(1'b0, 32'hAABBCCDD, 1'b0);
      send_byte(1'b0, 8'h0E, 1'b0);
      idle(2);
      chk("midrst_next_done", 65'(done0), 65'd1);
      chk("midrst_next_cpu_reset", 65'(cpu_reset0), 65'd0);
      check_writes("midrst_next");

      // non-zero base address, then bytes offered after DONE
      do_reset();
      got_q.delete();
      exp_q.push_back({1'b1, 32'h0000_0100, 32'hAABBCCDD});
      send_byte(1'b1, 8'h00, 1'b0);
      send_byte(1'b1, 8'h01, 1'b0);
      send_word(1'b1, 32'hAABBCCDD, 1'b0);
      send_byte(1'b1, 8'h0E, 1'b0);
      idle(1);
      chk("base_done", 65'(done1), 65'd1);
      check_writes("base");
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 1'b1, 8'($urandom_range(0, 255)));
         @(negedge clk);
         chk("base_after_in_ready", 65'(bus1.in_ready), 65'd0);
         @(posedge clk);
         #1;
      end
      set_in(1'b1, 1'b0, 8'h00);
      idle(2);
      chk("base_after_done", 65'(done1), 65'd1);
      chk("base_after_error", 65'(error1), 65'd0);
      chk("base_after_wc", 65'(word_count1), 65'd1);
      chk("base_after_cpu_reset", 65'(cpu_reset1), 65'd0);
      check_writes("base_after");

      chk("protocol", 65'(proto_err), 65'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the processor's program memory; the processor only fetches instructions from that memory.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the instruction memory's write port at consecutive word addresses.
- Holds the processor in reset until a frame is loaded and its checksum verifies.

Parameters:
BASE_ADDR, 32'h00000000, byte address of first word written
MAX_WORDS, 1024, largest accepted frame length in words (memory depth)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets block on next clk edge)
in_valid  input  1  in_byte holds a valid byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
in_byte  input  8  stream byte
mem_write  output  1  one-cycle write strobe to program memory write port
mem_address  output  32  byte address of write, word aligned
mem_write_data  output  32  assembled word
cpu_reset  output  1  active-high reset to processor; low only in DONE
busy  output  1  frame in progress (LEN_LO, DATA, WR, CSUM)
done  output  1  sticky, frame loaded and checksum good
error  output  1  sticky, bad length or checksum mismatch
word_count  output  16  words written so far in current frame

Behaviour:
- Reset (reset==0 at clk edge) gives:
  - state=LEN_HI, in_ready=1, mem_write=0, mem_address=BASE_ADDR, mem_write_data=0
  - cpu_reset=1, busy=0, done=0, error=0, word_count=0
  - checksum accumulator=0, byte index=0
- Frame format: LEN[15:8], LEN[7:0], then 4*LEN data bytes (MSB first per word), then CSUM. CSUM = sum of all data bytes mod 256.
- State LEN_HI: on transfer, latch LEN[15:8] -> LEN_LO.
- State LEN_LO: on transfer, latch LEN[7:0], then branch on LEN:
  - LEN > MAX_WORDS -> ERR
  - LEN == 0 -> CSUM
  - otherwise -> DATA
- State DATA:
  - Each transfer shifts the byte into the word (byte 0 lands in [31:24]), adds it to the checksum, and increments the byte index mod 4.
  - The transfer with byte index 3 -> WR.
- State WR (exactly one cycle):
  - in_ready=0, mem_write=1, mem_address=BASE_ADDR+4*word_count, mem_write_data=assembled word.
  - At the end of the cycle word_count increments.
  - Next state: DATA if word_count+1 < LEN, else CSUM.
- State CSUM: on transfer, compare byte with accumulator: equal -> DONE, else -> ERR.
- State DONE: in_ready=0, done=1, cpu_reset=0, busy=0. Stays until reset.
- State ERR: in_ready=0, error=1, cpu_reset=1. Stays until reset; no further writes.
- in_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM; it is 0 in WR, DONE and ERR.
- in_valid=0 stalls any state without side effects; in_byte is ignored when no transfer occurs.
- mem_write is only ever asserted in WR and never for two consecutive cycles. A byte cannot be accepted in the same cycle as a write.
- Address arithmetic is 32-bit and wraps modulo 2^32. word_count never exceeds MAX_WORDS.
- Reset mid-frame: abandon frame, return to reset values, keep cpu_reset=1. Words already written stay in memory and are overwritten by the next frame.
- Outputs are registered except in_ready, busy and cpu_reset, which decode from state.

Test Plan:
- Two-word load with in_valid held high, bytes 00 02 | 12 34 56 78 | 9A BC DE F0 | 38:
  - mem_write pulses twice: [00000000]=12345678 and [00000004]=9ABCDEF0.
  - in_ready=0 exactly in each write cycle.
  - done=1, cpu_reset falls, error=0, word_count=2.
- Same two-word frame with last byte 39 -> error=1, cpu_reset stays 1, done=0, and no further mem_write after the byte is sent.
- Length check:
  - LEN=0x0401 with MAX_WORDS=1024 -> ERR immediately after the second byte; zero writes.
  - LEN=0 followed by CSUM 00 -> DONE with zero writes.
- Random in_valid gaps (about 50% duty) on the two-word frame -> identical writes and addresses; no byte lost or duplicated.
- Reset mid-frame:
  - reset=0 for one cycle after 6 data bytes -> all outputs at reset values, no write issued.
  - A following valid one-word frame 00 01 | AA BB CC DD | 0E writes [00000000]=AABBCCDD and reaches DONE.
- BASE_ADDR=32'h00000100 one-word frame -> mem_address=00000100; after DONE, in_ready stays 0 and extra valid bytes are ignored.
